trng_harvester: RTL and testbench
=================================

Name: trng_harvester

Overview:
- Parametrised successor to the tinytrng top-level entropy path.
- Samples NUM_UNITS raw entropy bits on a divided bit clock and XOR-combines them into one bit per sample.
- Optionally applies von Neumann debiasing and runs a repetition-count health test on the combined samples.
- Packs accepted bits into WORD_WIDTH words and queues them in a FIFO with a valid/ready interface for a downstream consumer. Legacy serial random/pulse/bclk outputs are retained.

Parameters:
NUM_UNITS, 4, number of raw entropy inputs XOR-combined per sample (>=1)
XCLK_DIV, 16, clk cycles per sample; even, >=2
WORD_WIDTH, 8, bits per output word (>=2)
FIFO_DEPTH, 4, output FIFO entries; power of two, >=2
RCT_LIMIT, 32, consecutive identical combined samples that trip the health test (>=2)
DEBIAS, 1, 1 = von Neumann debiasing on; 0 = every sample accepted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
raw  input  NUM_UNITS  raw entropy bits, already synchronised to clk
enable  input  1  1 = harvesting runs
word_data  output  WORD_WIDTH  FIFO head word
word_valid  output  1  FIFO non-empty
word_ready  input  1  consumer accepts head when word_valid=1
fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
random  output  1  last accepted bit
pulse  output  1  one-cycle strobe per accepted bit
bclk  output  1  sample clock, registered
overflow  output  1  sticky; a completed word was dropped because the FIFO was full
health_fail  output  1  sticky; repetition-count test tripped

Behaviour:
- Reset values:
  - All outputs 0.
  - Divider = 0, shift count = 0, pair state empty, repetition count = 0, FIFO empty.
- Divider:
  - Counter runs 0..XCLK_DIV-1 and wraps while enable=1 and health_fail=0; otherwise it is held at 0.
  - bclk is registered: 1 while counter >= XCLK_DIV/2, else 0. Period is XCLK_DIV clk cycles, 50% duty.
  - Strobe fires in the cycle where counter == XCLK_DIV-1, i.e. at the end of the bclk high phase.
- Sample: on the strobe, s = XOR of all raw bits.
- Health test:
  - If s equals the previous sample, the repetition count increments; otherwise the count resets to 1. The first sample after reset or enable sets count = 1.
  - When the count reaches RCT_LIMIT, health_fail is set at that edge and the FIFO is flushed (fifo_level = 0 next cycle).
  - While health_fail=1: no further bits, pulses or pushes; word_valid stays 0. Only reset clears health_fail.
- Debias:
  - DEBIAS=0: s is accepted directly.
  - DEBIAS=1: the first sample of a pair is stored. On the second sample, if it differs from the first, the first sample is accepted; if equal, both are discarded. The pair state then empties.
- Accepted bit:
  - random <= bit, and pulse = 1 for exactly the cycle after the strobe edge.
  - Shift register <= {bit, sr[WORD_WIDTH-1:1]}, so the first accepted bit lands in the LSB.
- Word completion:
  - When the WORD_WIDTH-th bit is shifted in, the word is pushed at the next edge. word_valid rises 2 cycles after the strobe edge when the FIFO was empty.
  - Shift count then resets to 0.
- Push with FIFO full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the word is dropped and overflow is set (sticky until reset).
- FIFO:
  - Pop when word_valid && word_ready.
  - Strict order; word_data is the head, stable while word_valid=1 and not popped.
  - Simultaneous push and pop leaves fifo_level unchanged.
- enable deassert:
  - At the next edge the partial word, shift count, pair state and repetition count clear.
  - FIFO contents are retained and remain drainable. pulse stays 0.
- reset mid-operation: returns every register to its reset value at the next edge, including the FIFO and the sticky flags.

Test Plan:
1. Reset, then enable=1, XCLK_DIV=16 -> all outputs 0 during reset; afterwards bclk runs 8 cycles low / 8 high, and the first strobe occurs 16 cycles after enable.
2. DEBIAS=0, NUM_UNITS=4, combined samples 1,0,1,1,0,0,1,0 -> 8 pulses with random following the sequence; word_data=0x4D, word_valid=1 two cycles after the 8th strobe; fifo_level=1.
3. DEBIAS=1, sample pairs (0,1),(1,1),(1,0),(0,0) -> exactly two pulses, random=0 then 1; shift count = 2.
4. word_ready=0, produce 5 words 0x01..0x05 with FIFO_DEPTH=4 -> fifo_level=4, overflow=1; after word_ready=1, drain order is 0x01,0x02,0x03,0x04; a push coincident with a pop at full is accepted, overflow not set.
5. RCT_LIMIT=32: 31 identical samples then a change -> health_fail=0. 32 identical samples -> health_fail=1 at the 32nd strobe, fifo_level=0, no further pulses; only reset clears it.
6. Deassert enable after 3 bits of a word with 2 words queued -> partial word discarded, both queued words still drained intact; after re-enable, the next word is built from 8 fresh bits.

Source files
------------

// File: rtl/trng_harvester.sv
// rtl/trng_harvester.sv - entropy sampler with health test, debias, word packer and output FIFO
module trng_harvester #(
    parameter int NUM_UNITS  = 4,
    parameter int XCLK_DIV   = 16,
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_LIMIT  = 32,
    parameter int DEBIAS     = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_UNITS-1:0]               raw,
    input  logic                               enable,
    output logic [WORD_WIDTH-1:0]              word_data,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               random,
    output logic                               pulse,
    output logic                               bclk,
    output logic                               overflow,
    output logic                               health_fail
);
    localparam int CW  = (XCLK_DIV > 2) ? $clog2(XCLK_DIV) : 1;
    localparam int SCW = $clog2(WORD_WIDTH);
    localparam int RCW = $clog2(RCT_LIMIT + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   run, strobe, s, trip;
    logic [RCW-1:0]         rct_cnt, rct_nxt;
    logic                   prev_s;
    logic                   pair_full, pair_bit;
    logic                   acc, acc_bit;
    logic [WORD_WIDTH-2:0]  part;
    logic [WORD_WIDTH-1:0]  sr_nxt;
    logic [SCW-1:0]         shcnt;
    logic                   word_done;
    logic                   push_pending;
    logic [WORD_WIDTH-1:0]  push_word;
    logic [WORD_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   pop, full, push_ok, drop;

    assign run     = enable && !health_fail;
    assign cnt_nxt = !run ? '0 : (cnt == CW'(XCLK_DIV - 1)) ? '0 : cnt + CW'(1);
    assign strobe  = run && (cnt == CW'(XCLK_DIV - 1));
    assign s       = ^raw;
    assign rct_nxt = (rct_cnt != '0 && s == prev_s) ? rct_cnt + RCW'(1) : RCW'(1);
    assign trip    = strobe && (rct_nxt == RCW'(RCT_LIMIT));
    assign sr_nxt  = {acc_bit, part};
    assign word_done = acc && (shcnt == SCW'(WORD_WIDTH - 1));

    // Decide whether this strobe yields an accepted bit (direct or von Neumann)
    always_comb begin
        acc     = 1'b0;
        acc_bit = s;
        if (strobe && !trip) begin
            if (DEBIAS == 0) begin
                acc = 1'b1;
            end else if (pair_full && (s != pair_bit)) begin
                acc     = 1'b1;
                acc_bit = pair_bit;
            end
        end
    end

    // Bit-clock divider; bclk is registered from the next counter value
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            bclk <= (cnt_nxt >= CW'(XCLK_DIV / 2));
        end
    end

    // Health test, debias pairing, word assembly and legacy serial outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rct_cnt      <= '0;
            prev_s       <= 1'b0;
            pair_full    <= 1'b0;
            pair_bit     <= 1'b0;
            part         <= '0;
            shcnt        <= '0;
            random       <= 1'b0;
            pulse        <= 1'b0;
            health_fail  <= 1'b0;
            push_pending <= 1'b0;
            push_word    <= '0;
        end else begin
            push_pending <= word_done;
            if (word_done) push_word <= sr_nxt;
            if (!enable) begin
                rct_cnt   <= '0;
                prev_s    <= 1'b0;
                pair_full <= 1'b0;
                part      <= '0;
                shcnt     <= '0;
                pulse     <= 1'b0;
            end else begin
                pulse <= acc;
                if (strobe) begin
                    prev_s  <= s;
                    rct_cnt <= rct_nxt;
                end
                if (trip) health_fail <= 1'b1;
                if (strobe && !trip && DEBIAS != 0) begin
                    if (pair_full) begin
                        pair_full <= 1'b0;
                    end else begin
                        pair_full <= 1'b1;
                        pair_bit  <= s;
                    end
                end
                if (acc) begin
                    random <= acc_bit;
                    part   <= sr_nxt[WORD_WIDTH-1:1];
                    shcnt  <= word_done ? '0 : shcnt + SCW'(1);
                end
            end
        end
    end

    assign word_valid = (level != '0) && !health_fail;
    assign pop        = word_valid && word_ready;
    assign full       = (level == LW'(FIFO_DEPTH));
    assign push_ok    = push_pending && (!full || pop);
    assign drop       = push_pending && full && !pop;
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

    // FIFO pointers, occupancy and sticky overflow; a health trip flushes everything
    always_ff @(posedge clk) begin
        if (reset || trip) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            if (reset) overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop);
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok && !trip) mem[wr_ptr] <= push_word;
    end
endmodule

// File: tb/tb_trng_harvester.sv
// tb/tb_trng_harvester.sv - directed table-driven bench for trng_harvester
module tb_trng_harvester;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_a, raw_b;
    logic       en_a, en_b, rdy_a, rdy_b;
    logic [7:0] wd_a, wd_b;
    logic       wv_a, wv_b, rnd_a, rnd_b, pl_a, pl_b, bc_a, bc_b, ov_a, ov_b, hf_a, hf_b;
    logic [2:0] lv_a, lv_b;
    int errors = 0;
    int checks = 0;
    int pcnt_a = 0;
    int pbefore;

    typedef struct {
        logic [3:0] raw;
        logic       exp_pulse;
        logic       exp_random;
    } vec_t;
    vec_t tv2[8];
    vec_t tv3[8];

    always #5 clk = ~clk;

    trng_harvester #(.NUM_UNITS(4), .XCLK_DIV(16), .WORD_WIDTH(8), .FIFO_DEPTH(4),
                     .RCT_LIMIT(32), .DEBIAS(0)) ua (
        .clk(clk), .reset(reset), .raw(raw_a), .enable(en_a), .word_data(wd_a),
        .word_valid(wv_a), .word_ready(rdy_a), .fifo_level(lv_a), .random(rnd_a),
        .pulse(pl_a), .bclk(bc_a), .overflow(ov_a), .health_fail(hf_a));

    trng_harvester #(.NUM_UNITS(4), .XCLK_DIV(16), .WORD_WIDTH(8), .FIFO_DEPTH(4),
                     .RCT_LIMIT(32), .DEBIAS(1)) ub (
        .clk(clk), .reset(reset), .raw(raw_b), .enable(en_b), .word_data(wd_b),
        .word_valid(wv_b), .word_ready(rdy_b), .fifo_level(lv_b), .random(rnd_b),
        .pulse(pl_b), .bclk(bc_b), .overflow(ov_b), .health_fail(hf_b));

    always @(negedge clk) if (pl_a) pcnt_a++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic b);
        logic [2:0] h;
        h = 3'($urandom_range(0, 7));
        return {h, b ^ (^h)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        raw_a = '0; raw_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic samp_raw_a(input logic [3:0] r);
        raw_a = r;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic samp_a(input logic b);
        samp_raw_a(enc(b));
    endtask

    task automatic samp_raw_b(input logic [3:0] r);
        raw_b = r;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_word_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) samp_a(w[i]);
    endtask

    task automatic drain_a(input string name, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3, input int n);
        logic [7:0] exp [4];
        exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
        @(negedge clk);
        en_a = 1'b0;
        rdy_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({name, "_valid"}, wv_a, 1'b1);
            chk({name, "_data"}, wd_a, exp[i]);
            @(posedge clk); #1;
        end
        chk({name, "_empty"}, wv_a, 1'b0);
        rdy_a = 1'b0;
    endtask

    initial begin
        tv2[0] = '{4'b0001, 1'b1, 1'b1};
        tv2[1] = '{4'b0011, 1'b1, 1'b0};
        tv2[2] = '{4'b0111, 1'b1, 1'b1};
        tv2[3] = '{4'b1000, 1'b1, 1'b1};
        tv2[4] = '{4'b1111, 1'b1, 1'b0};
        tv2[5] = '{4'b0000, 1'b1, 1'b0};
        tv2[6] = '{4'b1011, 1'b1, 1'b1};
        tv2[7] = '{4'b0101, 1'b1, 1'b0};
        tv3[0] = '{4'b0000, 1'b0, 1'b0};
        tv3[1] = '{4'b0001, 1'b1, 1'b0};
        tv3[2] = '{4'b1110, 1'b0, 1'b0};
        tv3[3] = '{4'b0100, 1'b0, 1'b0};
        tv3[4] = '{4'b0010, 1'b0, 1'b0};
        tv3[5] = '{4'b1100, 1'b1, 1'b1};
        tv3[6] = '{4'b1001, 1'b0, 1'b1};
        tv3[7] = '{4'b0110, 1'b0, 1'b1};

        // reset values and divider waveform
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        raw_a = 4'hF; raw_b = 4'hF;
        repeat (3) @(posedge clk); #1;
        chk("rst_outs_a", {wd_a, wv_a, lv_a, rnd_a, pl_a, bc_a, ov_a, hf_a}, '0);
        chk("rst_outs_b", {wd_b, wv_b, lv_b, rnd_b, pl_b, bc_b, ov_b, hf_b}, '0);
        @(negedge clk);
        reset = 1'b0; en_a = 1'b1; raw_a = 4'b0000;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            chk($sformatf("bclk_%0d", j), bc_a, ((j + 1) % 16) >= 8);
            chk($sformatf("first_strobe_%0d", j), pl_a, j == 15);
        end

        // straight sampling, word 0x4D
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            samp_raw_a(tv2[i].raw);
            chk($sformatf("t2_pulse_%0d", i), pl_a, tv2[i].exp_pulse);
            chk($sformatf("t2_random_%0d", i), rnd_a, tv2[i].exp_random);
        end
        chk("t2_valid_early", wv_a, 1'b0);
        @(posedge clk); #1;
        chk("t2_pulse_off", pl_a, 1'b0);
        chk("t2_valid", wv_a, 1'b1);
        chk("t2_data", wd_a, 8'h4D);
        chk("t2_level", lv_a, 3'd1);

        // von Neumann pairs, then six (1,0) pairs complete word 0xFE
        do_reset();
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            samp_raw_b(tv3[i].raw);
            chk($sformatf("t3_pulse_%0d", i), pl_b, tv3[i].exp_pulse);
            chk($sformatf("t3_random_%0d", i), rnd_b, tv3[i].exp_random);
        end
        for (int i = 0; i < 6; i++) begin
            samp_raw_b(4'b0001);
            samp_raw_b(4'b0000);
        end
        chk("t3_valid_early", wv_b, 1'b0);
        @(posedge clk); #1;
        chk("t3_valid", wv_b, 1'b1);
        chk("t3_data", wd_b, 8'hFE);

        // overflow at full, then drain order
        do_reset();
        en_a = 1'b1;
        for (int w = 1; w <= 5; w++) send_word_a(8'(w));
        @(posedge clk); #1;
        chk("t4_level", lv_a, 3'd4);
        chk("t4_overflow", ov_a, 1'b1);
        drain_a("t4_drain", 8'h01, 8'h02, 8'h03, 8'h04, 4);

        // push coincident with pop at full
        do_reset();
        en_a = 1'b1;
        for (int w = 1; w <= 4; w++) send_word_a(8'(w));
        send_word_a(8'h05);
        rdy_a = 1'b1;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        chk("t4b_level", lv_a, 3'd4);
        chk("t4b_overflow", ov_a, 1'b0);
        drain_a("t4b_drain", 8'h02, 8'h03, 8'h04, 8'h05, 4);

        // repetition-count health test
        do_reset();
        en_a = 1'b1;
        for (int i = 0; i < 31; i++) samp_a(1'b1);
        samp_a(1'b0);
        chk("t5_hf_31", hf_a, 1'b0);
        for (int i = 0; i < 30; i++) samp_a(1'b0);
        chk("t5_hf_31b", hf_a, 1'b0);
        chk("t5_level_pre", lv_a, 3'd4);
        samp_a(1'b0);
        chk("t5_hf_trip", hf_a, 1'b1);
        chk("t5_pulse_trip", pl_a, 1'b0);
        chk("t5_level_flush", lv_a, 3'd0);
        chk("t5_valid_flush", wv_a, 1'b0);
        chk("t5_overflow", ov_a, 1'b1);
        pbefore = pcnt_a;
        rdy_a = 1'b1;
        repeat (40) @(posedge clk); #1;
        chk("t5_no_pulses", pcnt_a, pbefore);
        chk("t5_hf_sticky", hf_a, 1'b1);
        chk("t5_bclk_held", bc_a, 1'b0);
        do_reset();
        #1;
        chk("t5_hf_cleared", hf_a, 1'b0);
        chk("t5_ov_cleared", ov_a, 1'b0);

        // enable drop mid-word
        do_reset();
        en_a = 1'b1;
        send_word_a(8'hA5);
        send_word_a(8'h3C);
        samp_a(1'b1); samp_a(1'b1); samp_a(1'b0);
        @(negedge clk);
        en_a = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("t6_pulse_off", pl_a, 1'b0);
        chk("t6_level_kept", lv_a, 3'd2);
        @(negedge clk);
        en_a = 1'b1;
        send_word_a(8'h96);
        @(posedge clk); #1;
        chk("t6_level", lv_a, 3'd3);
        drain_a("t6_drain", 8'hA5, 8'h3C, 8'h96, 8'h00, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
